id_issue_queue: RTL and testbench

Decoupling queue between the decode stage and the issue stage. It buffers up to DEPTH decoded `scoreboard_entry_t` instructions with their control-flow flags, and presents them in order to the issue stage's `decoded_instr_*` handshake. It allows at most one issued, unresolved control-flow instruction at a time. It discards all buffered state on a pipeline flush.

---
 rtl/id_issue_queue.sv | 111 +++++++++++
 tb/tb_id_issue_queue.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_queue.sv
// In-order decode-to-issue buffer. Holds up to DEPTH decoded instructions and allows
// only one issued, unresolved control-flow instruction at a time.
module id_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter type scoreboard_entry_t = logic [31:0]
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  scoreboard_entry_t          decoded_instr_i,
  input  logic                       decoded_instr_valid_i,
  input  logic                       is_ctrl_flow_i,
  output logic                       decoded_instr_ack_o,
  output scoreboard_entry_t          issue_instr_o,
  output logic                       issue_instr_valid_o,
  output logic                       is_ctrl_flow_o,
  input  logic                       issue_instr_ack_i,
  input  logic                       resolve_branch_i,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [0:0] {BrIdle, BrPending} br_state_e;

  scoreboard_entry_t mem_entry_q [DEPTH];
  logic              mem_ctrl_q  [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  br_state_e     branch_pending_q, branch_pending_d;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_head_ctrl;

  assign w_full      = (cnt_q == CW'(DEPTH));
  assign w_head_ctrl = mem_ctrl_q[rd_ptr_q];

  // Acceptance only looks at the registered occupancy; a same-cycle pop never makes room.
  assign w_push = decoded_instr_valid_i & ~w_full & ~flush_i;

  assign issue_instr_valid_o = (cnt_q != '0)
                             & ~(w_head_ctrl & (branch_pending_q == BrPending))
                             & ~flush_i;
  assign w_pop = issue_instr_valid_o & issue_instr_ack_i;

  assign decoded_instr_ack_o = w_push;
  assign issue_instr_o       = mem_entry_q[rd_ptr_q];
  assign is_ctrl_flow_o      = w_head_ctrl;
  assign full_o              = w_full;
  assign count_o             = cnt_q;

  always_comb begin
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    cnt_d            = cnt_q;
    branch_pending_d = branch_pending_q;
    if (flush_i) begin
      rd_ptr_d         = '0;
      wr_ptr_d         = '0;
      cnt_d            = '0;
      branch_pending_d = BrIdle;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(w_push) - CW'(w_pop);
      // A newly issued branch wins over a coincident resolve.
      unique case (branch_pending_q)
        BrIdle: begin
          if (w_pop && w_head_ctrl) branch_pending_d = BrPending;
        end
        BrPending: begin
          if (w_pop && w_head_ctrl) branch_pending_d = BrPending;
          else if (resolve_branch_i) branch_pending_d = BrIdle;
        end
        default: branch_pending_d = BrIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      cnt_q            <= '0;
      branch_pending_q <= BrIdle;
    end else begin
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      cnt_q            <= cnt_d;
      branch_pending_q <= branch_pending_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      mem_entry_q[wr_ptr_q] <= decoded_instr_i;
      mem_ctrl_q[wr_ptr_q]  <= is_ctrl_flow_i;
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) !(w_pop && (cnt_q == '0)));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   !(w_push && !w_pop && (cnt_q == CW'(DEPTH))));

endmodule

// File: tb/tb_id_issue_queue.sv
// Directed self-checking bench for id_issue_queue with DEPTH=4.
module tb_id_issue_queue;

  logic        clk_i;
  logic        rst_ni;
  logic        flush_i;
  logic [31:0] decoded_instr_i;
  logic        decoded_instr_valid_i;
  logic        is_ctrl_flow_i;
  logic        decoded_instr_ack_o;
  logic [31:0] issue_instr_o;
  logic        issue_instr_valid_o;
  logic        is_ctrl_flow_o;
  logic        issue_instr_ack_i;
  logic        resolve_branch_i;
  logic        full_o;
  logic [2:0]  count_o;

  int checks;
  int errors;

  id_issue_queue #(
    .DEPTH(4)
  ) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .flush_i               (flush_i),
    .decoded_instr_i       (decoded_instr_i),
    .decoded_instr_valid_i (decoded_instr_valid_i),
    .is_ctrl_flow_i        (is_ctrl_flow_i),
    .decoded_instr_ack_o   (decoded_instr_ack_o),
    .issue_instr_o         (issue_instr_o),
    .issue_instr_valid_o   (issue_instr_valid_o),
    .is_ctrl_flow_o        (is_ctrl_flow_o),
    .issue_instr_ack_i     (issue_instr_ack_i),
    .resolve_branch_i      (resolve_branch_i),
    .full_o                (full_o),
    .count_o               (count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    decoded_instr_valid_i = 1'b0;
    issue_instr_ack_i     = 1'b0;
    #1;
    checks++;
    if (decoded_instr_ack_o !== 1'b0) begin
      errors++; $display("FAIL reset_ack: got %b expected 0", decoded_instr_ack_o);
    end
    checks++;
    if (issue_instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", issue_instr_valid_o);
    end
    checks++;
    if (full_o !== 1'b0) begin
      errors++; $display("FAIL reset_full: got %b expected 0", full_o);
    end
    checks++;
    if (count_o !== 3'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", count_o);
    end
  endtask

  task automatic test_fill_drain();
    for (int k = 0; k < 5; k++) begin
      decoded_instr_valid_i = 1'b1;
      decoded_instr_i       = 32'h100 + 32'(k);
      is_ctrl_flow_i        = 1'b0;
      issue_instr_ack_i     = 1'b0;
      #1;
      checks++;
      if (decoded_instr_ack_o !== (k < 4)) begin
        errors++; $display("FAIL fill_ack[%0d]: got %b expected %b", k, decoded_instr_ack_o, k < 4);
      end
      if (k < 4) step();
      else begin
        @(posedge clk_i);
        #1;
      end
    end
    checks++;
    if (full_o !== 1'b1 || count_o !== 3'd4) begin
      errors++; $display("FAIL fill_full: got full=%b count=%0d expected full=1 count=4",
                         full_o, count_o);
    end
    // 0x104 stays presented; it must be taken one cycle after the first pop.
    for (int j = 0; j < 5; j++) begin
      issue_instr_ack_i     = 1'b1;
      decoded_instr_valid_i = (j <= 1);
      #1;
      checks++;
      if (issue_instr_valid_o !== 1'b1 || issue_instr_o !== 32'h100 + 32'(j)) begin
        errors++; $display("FAIL drain_out[%0d]: got v=%b d=%0h expected v=1 d=%0h", j,
                           issue_instr_valid_o, issue_instr_o, 32'h100 + 32'(j));
      end
      if (j <= 1) begin
        checks++;
        if (decoded_instr_ack_o !== (j == 1)) begin
          errors++; $display("FAIL drain_ack[%0d]: got %b expected %b", j,
                             decoded_instr_ack_o, j == 1);
        end
      end
      step();
    end
    issue_instr_ack_i     = 1'b0;
    decoded_instr_valid_i = 1'b0;
    #1;
    checks++;
    if (count_o !== 3'd0 || issue_instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL drain_empty: got count=%0d v=%b expected 0 0",
                         count_o, issue_instr_valid_o);
    end
  endtask

  task automatic test_stream();
    decoded_instr_valid_i = 1'b1;
    decoded_instr_i       = 32'h200;
    is_ctrl_flow_i        = 1'b0;
    issue_instr_ack_i     = 1'b1;
    #1;
    checks++;
    if (issue_instr_valid_o !== 1'b0 || decoded_instr_ack_o !== 1'b1) begin
      errors++; $display("FAIL empty_boundary: got v=%b ack=%b expected v=0 ack=1",
                         issue_instr_valid_o, decoded_instr_ack_o);
    end
    step();
    for (int i = 1; i <= 20; i++) begin
      decoded_instr_i = 32'h200 + 32'(i);
      #1;
      checks++;
      if (issue_instr_valid_o !== 1'b1 || issue_instr_o !== 32'h200 + 32'(i - 1) ||
          count_o !== 3'd1 || decoded_instr_ack_o !== 1'b1) begin
        errors++; $display("FAIL stream[%0d]: got v=%b d=%0h cnt=%0d ack=%b expected 1 %0h 1 1",
                           i, issue_instr_valid_o, issue_instr_o, count_o,
                           decoded_instr_ack_o, 32'h200 + 32'(i - 1));
      end
      step();
    end
    decoded_instr_valid_i = 1'b0;
    #1;
    checks++;
    if (issue_instr_valid_o !== 1'b1 || issue_instr_o !== 32'h214) begin
      errors++; $display("FAIL stream_last: got v=%b d=%0h expected v=1 d=214",
                         issue_instr_valid_o, issue_instr_o);
    end
    step();
    issue_instr_ack_i = 1'b0;
    #1;
    checks++;
    if (count_o !== 3'd0) begin
      errors++; $display("FAIL stream_empty: got %0d expected 0", count_o);
    end
  endtask

  task automatic push_one(input logic [31:0] d, input logic c);
    decoded_instr_valid_i = 1'b1;
    decoded_instr_i       = d;
    is_ctrl_flow_i        = c;
    step();
    decoded_instr_valid_i = 1'b0;
    is_ctrl_flow_i        = 1'b0;
  endtask

  task automatic test_branch_gating();
    push_one(32'h301, 1'b1);
    push_one(32'h302, 1'b0);
    push_one(32'h303, 1'b1);
    push_one(32'h304, 1'b1);
    issue_instr_ack_i = 1'b1;
    #1;
    checks++;
    if (issue_instr_valid_o !== 1'b1 || issue_instr_o !== 32'h301 || is_ctrl_flow_o !== 1'b1) begin
      errors++; $display("FAIL br_b1: got v=%b d=%0h c=%b expected 1 301 1",
                         issue_instr_valid_o, issue_instr_o, is_ctrl_flow_o);
    end
    step();
    checks++;
    if (issue_instr_valid_o !== 1'b1 || issue_instr_o !== 32'h302) begin
      errors++; $display("FAIL br_alu: got v=%b d=%0h expected 1 302",
                         issue_instr_valid_o, issue_instr_o);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (issue_instr_valid_o !== 1'b0 || count_o !== 3'd2) begin
        errors++; $display("FAIL br_hold[%0d]: got v=%b cnt=%0d expected 0 2", i,
                           issue_instr_valid_o, count_o);
      end
      step();
    end
    resolve_branch_i = 1'b1;
    #1;
    checks++;
    if (issue_instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL br_resolve_cycle: got %b expected 0", issue_instr_valid_o);
    end
    step();
    // B2 pops while another resolve pulse arrives: the new branch must stay pending.
    #1;
    checks++;
    if (issue_instr_valid_o !== 1'b1 || issue_instr_o !== 32'h303) begin
      errors++; $display("FAIL br_b2_valid: got v=%b d=%0h expected 1 303",
                         issue_instr_valid_o, issue_instr_o);
    end
    step();
    resolve_branch_i = 1'b0;
    #1;
    checks++;
    if (issue_instr_valid_o !== 1'b0 || issue_instr_o !== 32'h304 || count_o !== 3'd1) begin
      errors++; $display("FAIL br_b3_blocked: got v=%b d=%0h cnt=%0d expected 0 304 1",
                         issue_instr_valid_o, issue_instr_o, count_o);
    end
    issue_instr_ack_i = 1'b0;
  endtask

  task automatic test_flush();
    push_one(32'h401, 1'b0);
    push_one(32'h402, 1'b0);
    checks++;
    if (count_o !== 3'd3) begin
      errors++; $display("FAIL flush_pre_count: got %0d expected 3", count_o);
    end
    flush_i               = 1'b1;
    decoded_instr_valid_i = 1'b1;
    decoded_instr_i       = 32'h4ff;
    issue_instr_ack_i     = 1'b1;
    #1;
    checks++;
    if (decoded_instr_ack_o !== 1'b0 || issue_instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL flush_cycle: got ack=%b v=%b expected 0 0",
                         decoded_instr_ack_o, issue_instr_valid_o);
    end
    step();
    flush_i               = 1'b0;
    decoded_instr_valid_i = 1'b0;
    issue_instr_ack_i     = 1'b0;
    #1;
    checks++;
    if (count_o !== 3'd0 || full_o !== 1'b0 || issue_instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL flush_after: got cnt=%0d full=%b v=%b expected 0 0 0",
                         count_o, full_o, issue_instr_valid_o);
    end
    push_one(32'h500, 1'b1);
    #1;
    checks++;
    if (issue_instr_valid_o !== 1'b1 || issue_instr_o !== 32'h500 || is_ctrl_flow_o !== 1'b1) begin
      errors++; $display("FAIL flush_new_branch: got v=%b d=%0h c=%b expected 1 500 1",
                         issue_instr_valid_o, issue_instr_o, is_ctrl_flow_o);
    end
  endtask

  task automatic test_async_reset();
    push_one(32'h501, 1'b0);
    push_one(32'h502, 1'b0);
    checks++;
    if (count_o !== 3'd3) begin
      errors++; $display("FAIL rst_pre_count: got %0d expected 3", count_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (count_o !== 3'd0 || full_o !== 1'b0 || issue_instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_async: got cnt=%0d full=%b v=%b expected 0 0 0",
                         count_o, full_o, issue_instr_valid_o);
    end
    step();
    rst_ni = 1'b1;
    #1;
    checks++;
    if (count_o !== 3'd0 || issue_instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_release: got cnt=%0d v=%b expected 0 0",
                         count_o, issue_instr_valid_o);
    end
  endtask

  initial begin
    checks                = 0;
    errors                = 0;
    rst_ni                = 1'b0;
    flush_i               = 1'b0;
    decoded_instr_i       = '0;
    decoded_instr_valid_i = 1'b0;
    is_ctrl_flow_i        = 1'b0;
    issue_instr_ack_i     = 1'b0;
    resolve_branch_i      = 1'b0;
    repeat (2) @(posedge clk_i);
    test_reset();
    #2;
    rst_ni = 1'b1;
    step();
    test_reset();
    test_fill_drain();
    test_stream();
    test_branch_gating();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
